// File: rtl/jpeg_hdmi_pkg.sv
// rtl/jpeg_hdmi_pkg.sv - shared types and helpers for the HDMI raster to 8x8 block converter
package jpeg_hdmi_pkg;

  localparam int BLOCK_SIZE = 8;
  localparam int PX_N       = 2;

  typedef logic signed [PX_N-1:0][7:0] px_bus_t;

  typedef enum logic [1:0] {
    WS_WAIT_SOF = 2'd0,
    WS_ARMED    = 2'd1,
    WS_ACTIVE   = 2'd2
  } wr_state_t;

  typedef enum logic {
    RS_IDLE  = 1'b0,
    RS_DRAIN = 1'b1
  } rd_state_t;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hdmi_blk_line_ram.sv
// rtl/hdmi_blk_line_ram.sv - one band bank: simple dual-port RAM, one write and one registered read port
module hdmi_blk_line_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hdmi_to_blocks.sv
// rtl/hdmi_to_blocks.sv - HDMI raster stream to 8x8 block stream via ping-pong 8-line band buffers
module hdmi_to_blocks
  import jpeg_hdmi_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hdmi_v_sync,
  input  logic                    hdmi_h_sync,
  input  logic                    hdmi_data_valid,
  input  logic signed [N-1:0][7:0] hdmi_data_y,
  input  logic signed [N-1:0][7:0] hdmi_data_cr,
  input  logic signed [N-1:0][7:0] hdmi_data_cb,
  output logic                    blk_valid,
  output logic signed [N-1:0][7:0] blk_data_y,
  output logic signed [N-1:0][7:0] blk_data_cr,
  output logic signed [N-1:0][7:0] blk_data_cb,
  output logic                    blk_sob,
  output logic                    blk_eob,
  output logic                    blk_sof,
  output logic                    err_ovf
);

  localparam int W   = X_RES / N;
  localparam int D   = BLOCK_SIZE * W;
  localparam int E   = BLOCK_SIZE / N;
  localparam int BPB = X_RES / BLOCK_SIZE;
  localparam int NB  = Y_RES / BLOCK_SIZE;
  localparam int AW  = cw(D);
  localparam int CW  = cw(W);
  localparam int EW  = cw(E);
  localparam int BW  = cw(BPB);
  localparam int NBW = cw(NB);
  localparam int PW  = 8 * N;
  localparam int DW  = 3 * PW;

  wr_state_t      r_wstate;
  logic [CW-1:0]  r_col;
  logic [2:0]     r_row;
  logic [NBW-1:0] r_band;
  logic           r_wsel;
  logic [1:0]     r_first;
  logic [1:0]     r_full;
  logic           r_err;

  rd_state_t      r_rstate;
  logic [EW-1:0]  r_e;
  logic [2:0]     r_r;
  logic [BW-1:0]  r_b;
  logic           r_rsel;
  logic           r_qsel;
  logic           r_vld;
  logic           r_sob;
  logic           r_eob;
  logic           r_sof;

  logic           w_wr_beat;
  logic           w_hs_resync;
  logic [CW-1:0]  w_col_eff;
  logic           w_col_last;
  logic           w_band_end;
  logic           w_ovf_write;
  logic [AW-1:0]  w_waddr;
  logic [DW-1:0]  w_wdata;
  logic           w_rd_en;
  logic           w_e_last;
  logic           w_r_last;
  logic           w_b_last;
  logic           w_drain_end;
  logic [AW-1:0]  w_raddr;
  logic [DW-1:0]  w_q0;
  logic [DW-1:0]  w_q1;
  logic [DW-1:0]  w_q;

  // v_sync has priority: a beat arriving with it is dropped rather than written
  assign w_wr_beat   = hdmi_data_valid && !hdmi_v_sync &&
                       (r_wstate == WS_ARMED || r_wstate == WS_ACTIVE);
  assign w_hs_resync = (r_wstate == WS_ACTIVE) && hdmi_h_sync && !hdmi_v_sync;
  assign w_col_eff   = w_hs_resync ? '0 : r_col;
  assign w_col_last  = (w_col_eff == CW'(W - 1));
  assign w_band_end  = w_wr_beat && (r_row == 3'd7) && w_col_last;
  assign w_waddr     = AW'(int'(r_row) * W + int'(w_col_eff));
  assign w_wdata     = {hdmi_data_y, hdmi_data_cr, hdmi_data_cb};
  assign w_ovf_write = w_wr_beat && r_full[r_wsel] && !(w_drain_end && (r_rsel == r_wsel));

  assign w_rd_en     = (r_rstate == RS_DRAIN) || r_full[r_rsel];
  assign w_e_last    = (r_e == EW'(E - 1));
  assign w_r_last    = (r_r == 3'd7);
  assign w_b_last    = (r_b == BW'(BPB - 1));
  assign w_drain_end = w_rd_en && w_e_last && w_r_last && w_b_last;
  assign w_raddr     = AW'(int'(r_r) * W + int'(r_b) * E + int'(r_e));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate <= WS_WAIT_SOF;
      r_col    <= '0;
      r_row    <= '0;
      r_band   <= '0;
      r_wsel   <= 1'b0;
      r_first  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_ovf_write || (w_hs_resync && r_col != '0)) begin
        r_err <= 1'b1;
      end
      if (hdmi_v_sync) begin
        r_wstate <= WS_ARMED;
        r_col    <= '0;
        r_row    <= '0;
        r_band   <= '0;
      end else if (w_wr_beat) begin
        r_wstate <= WS_ACTIVE;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + 3'd1;
        end else begin
          r_col <= w_col_eff + CW'(1);
        end
        if (w_band_end) begin
          r_wsel          <= ~r_wsel;
          r_first[r_wsel] <= (r_band == '0);
          if (r_band == NBW'(NB - 1)) begin
            r_band   <= '0;
            r_wstate <= WS_WAIT_SOF;
          end else begin
            r_band <= r_band + NBW'(1);
          end
        end
      end else if (w_hs_resync) begin
        r_col <= '0;
      end
    end
  end

  // Band-end set wins over drain-end clear only when a full bank is being overwritten
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_band_end && (r_wsel == 1'(i))) begin
          r_full[i] <= 1'b1;
        end else if (w_drain_end && (r_rsel == 1'(i))) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate <= RS_IDLE;
      r_e      <= '0;
      r_r      <= '0;
      r_b      <= '0;
      r_rsel   <= 1'b0;
      r_qsel   <= 1'b0;
      r_vld    <= 1'b0;
      r_sob    <= 1'b0;
      r_eob    <= 1'b0;
      r_sof    <= 1'b0;
    end else begin
      r_vld  <= w_rd_en;
      r_qsel <= r_rsel;
      r_sob  <= w_rd_en && (r_e == '0) && (r_r == '0);
      r_eob  <= w_rd_en && w_e_last && w_r_last;
      r_sof  <= w_rd_en && (r_e == '0) && (r_r == '0) && (r_b == '0) && r_first[r_rsel];
      if (w_rd_en) begin
        r_rstate <= RS_DRAIN;
        if (w_e_last) begin
          r_e <= '0;
          if (w_r_last) begin
            r_r <= '0;
            if (w_b_last) begin
              r_b      <= '0;
              r_rsel   <= ~r_rsel;
              r_rstate <= r_full[~r_rsel] ? RS_DRAIN : RS_IDLE;
            end else begin
              r_b <= r_b + BW'(1);
            end
          end else begin
            r_r <= r_r + 3'd1;
          end
        end else begin
          r_e <= r_e + EW'(1);
        end
      end else begin
        r_rstate <= RS_IDLE;
      end
    end
  end

  hdmi_blk_line_ram #(.DEPTH(D), .WIDTH(DW), .AW(AW)) u_bank0 (
    .clk     (clk),
    .i_we    (w_wr_beat && (r_wsel == 1'b0)),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en && (r_rsel == 1'b0)),
    .i_raddr (w_raddr),
    .o_rdata (w_q0)
  );

  hdmi_blk_line_ram #(.DEPTH(D), .WIDTH(DW), .AW(AW)) u_bank1 (
    .clk     (clk),
    .i_we    (w_wr_beat && (r_wsel == 1'b1)),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en && (r_rsel == 1'b1)),
    .i_raddr (w_raddr),
    .o_rdata (w_q1)
  );

  assign w_q         = r_qsel ? w_q1 : w_q0;
  assign blk_valid   = r_vld;
  assign blk_sob     = r_sob;
  assign blk_eob     = r_eob;
  assign blk_sof     = r_sof;
  assign err_ovf     = r_err;
  assign blk_data_y  = r_vld ? w_q[DW-1 -: PW]     : '0;
  assign blk_data_cr = r_vld ? w_q[2*PW-1 -: PW]   : '0;
  assign blk_data_cb = r_vld ? w_q[PW-1:0]         : '0;

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// tb/tb_hdmi_to_blocks.sv - scoreboard bench for hdmi_to_blocks at 16x16, two pixels per clock
module tb_hdmi_to_blocks;
  import jpeg_hdmi_pkg::*;

  localparam int N  = 2;
  localparam int XR = 16;
  localparam int YR = 16;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] cr;
    logic [15:0] cb;
    logic        sob;
    logic        eob;
    logic        sof;
  } beat_t;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    vs, hs, dv;
  px_bus_t dy, dcr, dcb;
  logic    bv, bsob, beob, bsof, berr;
  px_bus_t by, bcr, bcb;

  beat_t exp_q[$];
  int    sof_cyc[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    cyc = 0;
  int    t_first = -1;
  int    n_seen = 0;

  hdmi_to_blocks #(.N(N), .X_RES(XR), .Y_RES(YR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hdmi_v_sync     (vs),
    .hdmi_h_sync     (hs),
    .hdmi_data_valid (dv),
    .hdmi_data_y     (dy),
    .hdmi_data_cr    (dcr),
    .hdmi_data_cb    (dcb),
    .blk_valid       (bv),
    .blk_data_y      (by),
    .blk_data_cr     (bcr),
    .blk_data_cb     (bcb),
    .blk_sob         (bsob),
    .blk_eob         (beob),
    .blk_sof         (bsof),
    .err_ovf         (berr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int tag, input int row, input int col, input int comp);
    if (comp == 0) return 8'((row * 16 + col) % 128);
    if (comp == 1) return 8'(row * 3 + tag * 17);
    return 8'(col + tag * 16);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    beat_t g;
    beat_t e;
    g = {by, bcr, bcb, bsob, beob, bsof};
    if (bv) begin
      n_seen++;
      if (t_first < 0) t_first = cyc;
      if (bsof) sof_cyc.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_beat at cyc %0d: y=%h cr=%h cb=%h", cyc, g.y, g.cr, g.cb);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_miss++;
          $display("FAIL beat cyc %0d: got y=%h cr=%h cb=%h sob/eob/sof=%b%b%b expected y=%h cr=%h cb=%h sob/eob/sof=%b%b%b",
                   cyc, g.y, g.cr, g.cb, g.sob, g.eob, g.sof, e.y, e.cr, e.cb, e.sob, e.eob, e.sof);
        end
      end
    end else if (bsob || beob || bsof) begin
      n_vec++;
      n_miss++;
      $display("FAIL flag_without_valid at cyc %0d: sob/eob/sof=%b%b%b expected 000", cyc, bsob, beob, bsof);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      vs = 1'b0; hs = 1'b0; dv = 1'b0;
    end
  endtask

  task automatic vsync();
    tick();
    vs = 1'b1; hs = 1'b0; dv = 1'b0;
  endtask

  task automatic beat(input int tag, input int row, input int colpx);
    tick();
    vs = 1'b0; hs = 1'b0; dv = 1'b1;
    for (int k = 0; k < N; k++) begin
      dy[k]  = pix(tag, row, colpx + k, 0);
      dcr[k] = pix(tag, row, colpx + k, 1);
      dcb[k] = pix(tag, row, colpx + k, 2);
    end
  endtask

  task automatic push_band(input int tag, input int band);
    beat_t e;
    int row, col;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        for (int q = 0; q < 4; q++) begin
          row   = band * 8 + r;
          col   = b * 8 + q * 2;
          e.y   = {pix(tag, row, col + 1, 0), pix(tag, row, col, 0)};
          e.cr  = {pix(tag, row, col + 1, 1), pix(tag, row, col, 1)};
          e.cb  = {pix(tag, row, col + 1, 2), pix(tag, row, col, 2)};
          e.sob = (r == 0 && q == 0);
          e.eob = (r == 7 && q == 3);
          e.sof = (r == 0 && q == 0 && b == 0 && band == 0);
          exp_q.push_back(e);
        end
  endtask

  task automatic send_band(input int tag, input int band, input bit push, output int t_end);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < XR; c += N)
        beat(tag, band * 8 + r, c);
    t_end = cyc;
    if (push) push_band(tag, band);
  endtask

  task automatic send_frame(input int tag, input bit push, output int t0);
    int t1;
    vsync();
    send_band(tag, 0, push, t0);
    send_band(tag, 1, push, t1);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      idle(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_a, t_b, t_x, seen0;
    rst_n = 1'b0; vs = 1'b0; hs = 1'b0; dv = 1'b0;
    dy = '0; dcr = '0; dcb = '0;
    idle(3);
    chk("rst_valid", int'(bv), 0);
    chk("rst_flags", int'({bsob, beob, bsof}), 0);
    chk("rst_err", int'(berr), 0);
    chk("rst_data_y", int'(by), 0);
    tick();
    rst_n = 1'b1;
    idle(2);

    send_frame(0, 1'b1, t_a);
    send_frame(1, 1'b1, t_b);
    idle(1);
    wait_drain(400);
    chk("band0_latency", t_first, t_a + 2);
    chk("sof_count", sof_cyc.size(), 2);
    if (sof_cyc.size() >= 2) chk("sof_gap", sof_cyc[1] - sof_cyc[0], 129);
    chk("err_b2b", int'(berr), 0);

    vsync();
    beat(7, 0, 0);
    beat(7, 0, 2);
    beat(7, 0, 4);
    tick();
    vs = 1'b0; hs = 1'b1; dv = 1'b0;
    chk("err_before_hsync", int'(berr), 0);
    tick();
    hs = 1'b0;
    chk("err_after_hsync", int'(berr), 1);
    send_band(2, 0, 1'b1, t_x);
    send_band(2, 1, 1'b1, t_x);
    idle(1);
    wait_drain(400);

    vsync();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < XR; c += N)
        beat(3, r, c);
    beat(3, 3, 0);
    beat(3, 3, 2);
    send_frame(4, 1'b1, t_x);
    idle(1);
    wait_drain(400);

    vsync();
    send_band(5, 0, 1'b1, t_x);
    idle(9);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", int'(bv), 0);
    chk("rst_mid_flags", int'({bsob, beob, bsof}), 0);
    chk("rst_mid_data_cb", int'(bcb), 0);
    chk("rst_mid_err", int'(berr), 0);
    chk("rst_mid_popped", exp_q.size(), 56);
    exp_q.delete();
    idle(2);
    tick();
    rst_n = 1'b1;
    seen0 = n_seen;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < XR; c += N)
        beat(5, r, c);
    idle(100);
    chk("silent_after_rst", n_seen - seen0, 0);

    send_frame(6, 1'b1, t_x);
    idle(1);
    wait_drain(400);
    chk("err_end", int'(berr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
